// File: rtl/wb_stage_ex_pkg.sv
// Shared definitions for the write-back stage: bus widths, load op encodings
// and exception codes used across the pipeline.
package wb_stage_ex_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // {ex, excode, ld_wait, ld_op, ld_off, gr_we, dest, result, pc}
    function automatic int ms_to_ws_bus_wd(input int reg_aw, input int pc_w, input int exc_w);
        return 1 + exc_w + 1 + 3 + 2 + 1 + reg_aw + DATA_W + pc_w;
    endfunction

    function automatic int ws_to_rf_bus_wd(input int reg_aw);
        return 1 + reg_aw + DATA_W;
    endfunction

    function automatic int ws_to_id_bus_wd(input int reg_aw);
        return 2 + reg_aw + DATA_W;
    endfunction

    localparam int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(5, 32, 5);
    localparam int WS_TO_RF_BUS_WD = ws_to_rf_bus_wd(5);
    localparam int WS_TO_ID_BUS_WD = ws_to_id_bus_wd(5);

endpackage

// File: rtl/wb_stage_ex_load_align.sv
// Combinational load data alignment: picks the addressed byte/half of the
// returned word and sign- or zero-extends it.
module wb_stage_ex_load_align
    import wb_stage_ex_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] raw,
    output logic [31:0] aligned
);

    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = raw[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[ld_off];
    assign w_half = ld_off[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        aligned = raw;
        case (ld_op_e'(ld_op))
            LD_B:    aligned = {{24{w_byte[7]}}, w_byte};
            LD_BU:   aligned = {24'd0, w_byte};
            LD_H:    aligned = {{16{w_half[15]}}, w_half};
            LD_HU:   aligned = {16'd0, w_half};
            default: aligned = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage_ex.sv
// Write-back stage: retires one instruction per cycle, waits for late load
// data, forwards/stalls decode, commits exceptions as a flush, counts retires.
module wb_stage_ex
    import wb_stage_ex_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 64
) (
    input  logic                                         clk,
    input  logic                                         reset,
    output logic                                         ws_allowin,
    input  logic                                         ms_to_ws_valid,
    input  logic [ms_to_ws_bus_wd(REG_AW, PC_W, EXC_W)-1:0] ms_to_ws_bus,
    input  logic                                         data_rdata_valid,
    input  logic [31:0]                                  data_rdata,
    output logic [ws_to_rf_bus_wd(REG_AW)-1:0]           ws_to_rf_bus,
    output logic [ws_to_id_bus_wd(REG_AW)-1:0]           ws_to_id_bus,
    output logic                                         ws_flush,
    output logic [PC_W-1:0]                              ws_epc,
    output logic [EXC_W-1:0]                             ws_excode,
    output logic [CNT_W-1:0]                             instret,
    output logic [31:0]                                  debug_wb_pc,
    output logic [3:0]                                   debug_wb_rf_wen,
    output logic [4:0]                                   debug_wb_rf_wnum,
    output logic [31:0]                                  debug_wb_rf_wdata
);

    localparam int BUS_W      = ms_to_ws_bus_wd(REG_AW, PC_W, EXC_W);
    localparam int OFF_RES    = PC_W;
    localparam int OFF_DEST   = OFF_RES + 32;
    localparam int OFF_WE     = OFF_DEST + REG_AW;
    localparam int OFF_LDOFF  = OFF_WE + 1;
    localparam int OFF_LDOP   = OFF_LDOFF + 2;
    localparam int OFF_LDWAIT = OFF_LDOP + 3;
    localparam int OFF_EXC    = OFF_LDWAIT + 1;
    localparam int OFF_EX     = OFF_EXC + EXC_W;

    logic              r_ws_valid;
    logic [BUS_W-1:0]  r_bus;
    logic              r_got_rsp;
    logic [31:0]       r_rsp_hold;
    logic [CNT_W-1:0]  r_instret;

    logic              w_ex;
    logic [EXC_W-1:0]  w_excode;
    logic              w_ld_wait;
    logic [2:0]        w_ld_op;
    logic [1:0]        w_ld_off;
    logic              w_gr_we;
    logic [REG_AW-1:0] w_dest;
    logic [31:0]       w_result;
    logic [PC_W-1:0]   w_pc;

    logic              w_ready_go;
    logic              w_retire;
    logic              w_flush;
    logic              w_we;
    logic              w_capture;
    logic [31:0]       w_raw;
    logic [31:0]       w_aligned;
    logic [31:0]       w_final;
    logic              w_fwd_valid;
    logic              w_block;

    assign w_pc      = r_bus[0 +: PC_W];
    assign w_result  = r_bus[OFF_RES +: 32];
    assign w_dest    = r_bus[OFF_DEST +: REG_AW];
    assign w_gr_we   = r_bus[OFF_WE];
    assign w_ld_off  = r_bus[OFF_LDOFF +: 2];
    assign w_ld_op   = r_bus[OFF_LDOP +: 3];
    assign w_ld_wait = r_bus[OFF_LDWAIT];
    assign w_excode  = r_bus[OFF_EXC +: EXC_W];
    assign w_ex      = r_bus[OFF_EX];

    assign w_ready_go = !w_ld_wait || r_got_rsp || data_rdata_valid;
    assign ws_allowin = !r_ws_valid || w_ready_go;
    assign w_retire   = r_ws_valid && w_ready_go;
    assign w_flush    = w_retire && w_ex;
    assign w_we       = w_retire && w_gr_we && !w_ex;
    assign w_capture  = r_ws_valid && w_ld_wait && !r_got_rsp && data_rdata_valid && !w_retire;

    // A held response takes priority; otherwise the live strobe is bypassed.
    assign w_raw = r_got_rsp ? r_rsp_hold : data_rdata;

    wb_stage_ex_load_align u_load_align (
        .ld_op   (w_ld_op),
        .ld_off  (w_ld_off),
        .raw     (w_raw),
        .aligned (w_aligned)
    );

    assign w_final     = w_ld_wait ? w_aligned : w_result;
    assign w_fwd_valid = r_ws_valid && w_gr_we && !w_ex && w_ready_go;
    assign w_block     = r_ws_valid && w_gr_we && !w_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_bus      <= '0;
            r_got_rsp  <= 1'b0;
            r_rsp_hold <= 32'd0;
            r_instret  <= '0;
        end else begin
            // A committed exception discards whatever MS offers this cycle.
            if (w_flush) begin
                r_ws_valid <= 1'b0;
            end else if (ws_allowin) begin
                r_ws_valid <= ms_to_ws_valid;
            end
            if (ws_allowin && ms_to_ws_valid && !w_flush) begin
                r_bus <= ms_to_ws_bus;
            end
            if (ws_allowin) begin
                r_got_rsp <= 1'b0;
            end else if (w_capture) begin
                r_got_rsp  <= 1'b1;
                r_rsp_hold <= data_rdata;
            end
            if (w_retire && !w_ex) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign ws_to_rf_bus      = {w_we, w_dest, w_final};
    assign ws_to_id_bus      = {w_fwd_valid, w_block, w_dest, w_final};
    assign ws_flush          = w_flush;
    assign ws_epc            = w_pc;
    assign ws_excode         = w_excode;
    assign instret           = r_instret;
    assign debug_wb_pc       = 32'(w_pc);
    assign debug_wb_rf_wen   = {4{w_we}};
    assign debug_wb_rf_wnum  = 5'(w_dest);
    assign debug_wb_rf_wdata = w_final;

endmodule

// File: tb/tb_wb_stage_ex.sv
// Bench for wb_stage_ex: directed vector table, hand-written corner sequences
// and a randomized run against a cycle-level reference model.
module tb_wb_stage_ex;
    import wb_stage_ex_pkg::*;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        ldw;
        logic [2:0]  op;
        logic [1:0]  off;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        ins_t        ins;
        int          delay;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic        exp_flush;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic        data_rdata_valid;
    logic [31:0] data_rdata;
    logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
    logic [WS_TO_ID_BUS_WD-1:0] ws_to_id_bus;
    logic        ws_flush;
    logic [31:0] ws_epc;
    logic [4:0]  ws_excode;
    logic [63:0] instret;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage_ex #(.REG_AW(5), .PC_W(32), .EXC_W(5), .CNT_W(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_rdata_valid  (data_rdata_valid),
        .data_rdata        (data_rdata),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_to_id_bus      (ws_to_id_bus),
        .ws_flush          (ws_flush),
        .ws_epc            (ws_epc),
        .ws_excode         (ws_excode),
        .instret           (instret),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model: the instruction currently sitting in WB
    logic            m_valid;
    ins_t            m_ins;
    longint unsigned m_instret;

    // DUT outputs captured at the sampling edge of the last step
    logic        cap_we, cap_allow, cap_block, cap_fwd, cap_flush;
    logic [4:0]  cap_waddr, cap_excode;
    logic [31:0] cap_wdata, cap_epc;
    logic [63:0] cap_instret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] align_ref(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] raw);
        int unsigned b, h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic step(input logic rst, input logic mv, input ins_t ins,
                        input logic rv, input logic [31:0] rd);
        logic ready, retire, e_we, e_fwd, e_blk, e_fl;
        logic [31:0] fin;
        reset            = rst;
        ms_to_ws_valid   = mv;
        ms_to_ws_bus     = ins;
        data_rdata_valid = rv;
        data_rdata       = rd;
        @(negedge clk);
        ready  = !m_ins.ldw || rv;
        retire = m_valid && ready;
        e_we   = retire && m_ins.we && !m_ins.ex;
        e_fwd  = m_valid && m_ins.we && !m_ins.ex && ready;
        e_blk  = m_valid && m_ins.we && !ready;
        e_fl   = retire && m_ins.ex;
        fin    = m_ins.ldw ? align_ref(m_ins.op, m_ins.off, rd) : m_ins.res;

        cap_we      = ws_to_rf_bus[37];
        cap_waddr   = ws_to_rf_bus[36:32];
        cap_wdata   = ws_to_rf_bus[31:0];
        cap_fwd     = ws_to_id_bus[38];
        cap_block   = ws_to_id_bus[37];
        cap_allow   = ws_allowin;
        cap_flush   = ws_flush;
        cap_epc     = ws_epc;
        cap_excode  = ws_excode;
        cap_instret = instret;

        check("allowin", cap_allow, !m_valid || ready);
        check("rf_we", cap_we, e_we);
        check("dbg_wen", debug_wb_rf_wen, {4{e_we}});
        if (e_we) begin
            check("rf_waddr", cap_waddr, m_ins.dest);
            check("rf_wdata", cap_wdata, fin);
            check("dbg_wnum", debug_wb_rf_wnum, m_ins.dest);
            check("dbg_wdata", debug_wb_rf_wdata, fin);
            check("dbg_pc", debug_wb_pc, m_ins.pc);
        end
        check("fwd_valid", cap_fwd, e_fwd);
        if (e_fwd) begin
            check("fwd_dest", ws_to_id_bus[36:32], m_ins.dest);
            check("fwd_value", ws_to_id_bus[31:0], fin);
        end
        check("block", cap_block, e_blk);
        check("flush", cap_flush, e_fl);
        if (e_fl) begin
            check("epc", cap_epc, m_ins.pc);
            check("excode", cap_excode, m_ins.excode);
        end
        check("instret", cap_instret, m_instret);
        if (retire)
            $display("retire pc=%h ex=%0d we=%0d rd=%0d data=%h instret=%0d",
                     m_ins.pc, m_ins.ex, e_we, m_ins.dest, fin, m_instret);

        @(posedge clk);
        if (rst) begin
            m_valid   = 1'b0;
            m_instret = 0;
        end else begin
            if (retire && !m_ins.ex) m_instret++;
            if (retire && m_ins.ex) begin
                m_valid = 1'b0;
            end else if (!m_valid || retire) begin
                m_valid = mv;
                if (mv) m_ins = ins;
            end
        end
        #1;
    endtask

    vec_t tbl[8];
    ins_t ins;
    int   nwr;
    logic [63:0] ir_save;

    initial begin
        tbl[0] = '{'{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd5,  32'h1234_5678, 32'hBFC0_0000}, 0, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        tbl[1] = '{'{1'b0, 5'd0, 1'b1, 3'd1, 2'd3, 1'b1, 5'd6,  32'h0,         32'hBFC0_0004}, 2, 32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80, 1'b0};
        tbl[2] = '{'{1'b0, 5'd0, 1'b1, 3'd4, 2'd2, 1'b1, 5'd7,  32'h0,         32'hBFC0_0008}, 0, 32'hBEEF_0001, 1'b1, 32'h0000_BEEF, 1'b0};
        tbl[3] = '{'{1'b0, 5'd0, 1'b1, 3'd0, 2'd0, 1'b1, 5'd8,  32'h0,         32'hBFC0_000C}, 1, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, 1'b0};
        tbl[4] = '{'{1'b0, 5'd0, 1'b1, 3'd2, 2'd1, 1'b1, 5'd9,  32'h0,         32'hBFC0_0010}, 0, 32'h1234_A578, 1'b1, 32'h0000_00A5, 1'b0};
        tbl[5] = '{'{1'b0, 5'd0, 1'b1, 3'd3, 2'd0, 1'b1, 5'd10, 32'h0,         32'hBFC0_0014}, 3, 32'h0001_8001, 1'b1, 32'hFFFF_8001, 1'b0};
        tbl[6] = '{'{1'b1, 5'd4, 1'b0, 3'd0, 2'd0, 1'b1, 5'd11, 32'h55,        32'hBFC0_0100}, 0, 32'h0,         1'b0, 32'h0,         1'b1};
        tbl[7] = '{'{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b0, 5'd12, 32'h77,        32'hBFC0_0018}, 0, 32'h0,         1'b0, 32'h0,         1'b0};

        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0;
        data_rdata_valid = 1'b0; data_rdata = 32'h0;
        m_valid = 1'b0; m_ins = '0; m_instret = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("rst_we", cap_we, 1'b0);
        check("rst_flush", cap_flush, 1'b0);
        check("rst_block", cap_block, 1'b0);
        check("rst_fwd", cap_fwd, 1'b0);
        check("rst_instret", cap_instret, 64'd0);

        // directed vectors: accept, stall for 'delay' cycles, then retire
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, tbl[i].ins, 1'b0, 32'h0);
            for (int d = 0; d < tbl[i].delay; d++) begin
                step(1'b0, 1'b0, '0, 1'b0, 32'hDEAD_0000);
                check("tbl_stall_allowin", cap_allow, 1'b0);
                check("tbl_stall_block", cap_block, tbl[i].ins.we);
            end
            step(1'b0, 1'b0, '0, tbl[i].ins.ldw, tbl[i].rdata);
            check("tbl_we", cap_we, tbl[i].exp_we);
            if (tbl[i].exp_we) check("tbl_wdata", cap_wdata, tbl[i].exp_wdata);
            check("tbl_flush", cap_flush, tbl[i].exp_flush);
            check("tbl_allowin", cap_allow, 1'b1);
        end
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("tbl_instret", cap_instret, 64'd7);

        // exception with a concurrent MS instruction: flush wins
        ins = '{1'b1, 5'd4, 1'b0, 3'd0, 2'd0, 1'b1, 5'd2, 32'h1, 32'hBFC0_0100};
        step(1'b0, 1'b1, ins, 1'b0, 32'h0);
        ir_save = cap_instret;
        ins = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd9, 32'h99, 32'hBFC0_0104};
        step(1'b0, 1'b1, ins, 1'b0, 32'h0);
        check("exc_flush", cap_flush, 1'b1);
        check("exc_epc", cap_epc, 32'hBFC0_0100);
        check("exc_code", cap_excode, 5'd4);
        check("exc_we", cap_we, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("exc_discard_we", cap_we, 1'b0);
        check("exc_instret", cap_instret, ir_save);

        // reset while a load waits, then a stray response
        ins = '{1'b0, 5'd0, 1'b1, 3'd0, 2'd0, 1'b1, 5'd3, 32'h0, 32'hBFC0_0200};
        step(1'b0, 1'b1, ins, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("rw_block", cap_block, 1'b1);
        check("rw_allowin", cap_allow, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0, 1'b1, 32'h1357_9BDF);
        check("rw_stray_we", cap_we, 1'b0);
        check("rw_allowin_after", cap_allow, 1'b1);
        check("rw_instret", cap_instret, 64'd0);
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("rw_no_capture_we", cap_we, 1'b0);

        // ten back-to-back ALU instructions
        nwr = 0;
        for (int i = 0; i < 11; i++) begin
            ins = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1, 5'(i + 1), 32'(i * 3 + 1), 32'(32'h8000_0000 + i * 4)};
            step(1'b0, (i < 10), ins, 1'b0, 32'h0);
            check("b2b_allowin", cap_allow, 1'b1);
            if (cap_we) nwr++;
            if (i > 0) begin
                check("b2b_we", cap_we, 1'b1);
                check("b2b_waddr", cap_waddr, 5'(i));
            end
        end
        step(1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("b2b_nwrites", 64'(nwr), 64'd10);
        check("b2b_instret", cap_instret, 64'd10);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            ins.ex     = ($urandom_range(0, 7) == 0);
            ins.excode = 5'($urandom_range(0, 31));
            ins.ldw    = 1'($urandom_range(0, 1));
            ins.op     = 3'($urandom_range(0, 4));
            ins.off    = 2'($urandom_range(0, 3));
            ins.we     = 1'($urandom_range(0, 1));
            ins.dest   = 5'($urandom_range(0, 31));
            ins.res    = $urandom;
            ins.pc     = $urandom;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ins,
                 ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
